// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit beside the main ALU: shift-add multiply and
// restoring divide, unsigned or signed, with a start/done handshake and cc update.
module alu_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hold,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   left,
   input  logic [WIDTH-1:0]   right,
   input  logic [7:0]         cc_in,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] result,
   output logic [7:0]         cc_out
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);
   localparam int CC_C = 0;
   localparam int CC_V = 1;
   localparam int CC_Z = 2;
   localparam int CC_N = 3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       cc_q, cc_d;
   logic [W2-1:0]    result_q, result_d;
   logic [7:0]       cc_out_q, cc_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   rem_diff;
   logic [W2-1:0]    mul_nx, div_nx, acc_nx;
   logic [W2-1:0]    mul_prod;
   logic [WIDTH-1:0] quo, rem, quo_f, rem_f;
   logic [W2-1:0]    fin_result;
   logic [7:0]       fin_cc;
   logic             is_signed, l_neg, r_neg;
   logic [WIDTH-1:0] l_mag, r_mag;

   // Multiplier LSB gates the multiplicand into the upper half each step.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = b_q[gi] & acc_q[0];
   end

   always_comb begin
      mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, addend};
      mul_nx   = {mul_sum, acc_q[WIDTH-1:1]};
      rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      if (rem_sh >= {1'b0, b_q}) begin
         div_nx = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
         div_nx = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
      acc_nx = op_q[1] ? div_nx : mul_nx;

      // Final-step result with sign fix-up folded into the same write.
      mul_prod = qneg_q ? -acc_nx : acc_nx;
      quo      = acc_nx[WIDTH-1:0];
      rem      = acc_nx[W2-1:WIDTH];
      quo_f    = qneg_q ? -quo : quo;
      rem_f    = rneg_q ? -rem : rem;
      fin_cc   = cc_q;
      if (!op_q[1]) begin
         fin_result   = mul_prod;
         fin_cc[CC_C] = mul_prod[WIDTH-1];
         if (op_q[0]) begin
            fin_cc[CC_V] = 1'b0;
            fin_cc[CC_Z] = (mul_prod == '0);
            fin_cc[CC_N] = mul_prod[W2-1];
         end
      end else begin
         fin_result   = {rem_f, quo_f};
         fin_cc[CC_C] = 1'b0;
         fin_cc[CC_V] = ovf_q;
         fin_cc[CC_Z] = (quo_f == '0);
         fin_cc[CC_N] = quo_f[WIDTH-1];
      end
   end

   always_comb begin
      is_signed = op[0];
      l_neg     = is_signed & left[WIDTH-1];
      r_neg     = is_signed & right[WIDTH-1];
      l_mag     = l_neg ? -left : left;
      r_mag     = r_neg ? -right : right;

      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      b_d      = b_q;
      acc_d    = acc_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      ovf_d    = ovf_q;
      cc_d     = cc_q;
      result_d = result_q;
      cc_out_d = cc_out_q;
      busy_d   = busy_q;
      done_d   = done_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b0;
            state_d = S_IDLE;
            if (start) begin
               op_d   = op;
               cc_d   = cc_in;
               b_d    = r_mag;
               acc_d  = {{WIDTH{1'b0}}, l_mag};
               qneg_d = l_neg ^ r_neg;
               rneg_d = op[1] & l_neg;
               ovf_d  = (op == 2'b11) && (left == {1'b1, {(WIDTH-1){1'b0}}})
                        && (right == {WIDTH{1'b1}});
               cnt_d  = '0;
               if (op[1] && (right == '0)) begin
                  state_d        = S_DONE;
                  done_d         = 1'b1;
                  result_d       = {left, {WIDTH{1'b1}}};
                  cc_out_d       = cc_in;
                  cc_out_d[CC_C] = 1'b1;
                  cc_out_d[CC_V] = 1'b1;
                  cc_out_d[CC_Z] = 1'b0;
                  cc_out_d[CC_N] = 1'b0;
               end else begin
                  state_d = S_RUN;
                  busy_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            acc_d = acc_nx;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d  = S_DONE;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               result_d = fin_result;
               cc_out_d = fin_cc;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= 2'b00;
         b_q      <= '0;
         acc_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cc_q     <= 8'h00;
         result_q <= '0;
         cc_out_q <= 8'hC0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (!hold) begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         ovf_q    <= ovf_d;
         cc_q     <= cc_d;
         result_q <= result_d;
         cc_out_q <= cc_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign cc_out = cc_out_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=8): directed plan vectors, random ops
// against an arithmetic reference model, and handshake/hold/reset sequences.
module tb_alu_muldiv;
   logic        clk = 1'b0;
   logic        rst;
   logic        hold;
   logic        start;
   logic [1:0]  op;
   logic [7:0]  left;
   logic [7:0]  right;
   logic [7:0]  cc_in;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic [7:0]  cc_out;

   int errors = 0;
   int checks = 0;

   alu_muldiv #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .hold(hold), .start(start), .op(op),
      .left(left), .right(right), .cc_in(cc_in),
      .busy(busy), .done(done), .result(result), .cc_out(cc_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) check("busy_done_excl", {31'd0, busy & done}, 32'd0);
   end

   // Reference: plain integer arithmetic, returns {result, cc_out}.
   function automatic logic [23:0] ref_model(input logic [1:0] o, input logic [7:0] l,
                                             input logic [7:0] r, input logic [7:0] cc);
      int a, b, p, q, rm;
      logic [15:0] res;
      logic [7:0]  c;
      c = cc;
      res = 16'h0;
      if (o == 2'd0) begin
         p = int'(l) * int'(r);
         res = p[15:0];
         c[0] = res[7];
      end else if (o == 2'd1) begin
         p = int'($signed(l)) * int'($signed(r));
         res = p[15:0];
         c[0] = res[7]; c[1] = 1'b0; c[2] = (res == 16'h0); c[3] = res[15];
      end else if (r == 8'h00) begin
         res = {l, 8'hFF};
         c[0] = 1'b1; c[1] = 1'b1; c[2] = 1'b0; c[3] = 1'b0;
      end else begin
         if (o == 2'd2) begin
            a = int'(l); b = int'(r);
         end else begin
            a = int'($signed(l)); b = int'($signed(r));
         end
         q  = a / b;
         rm = a % b;
         res = {rm[7:0], q[7:0]};
         c[0] = 1'b0;
         c[1] = (o == 2'd3) && (l == 8'h80) && (r == 8'hFF);
         c[2] = (q[7:0] == 8'h00);
         c[3] = q[7];
      end
      return {res, c};
   endfunction

   // Called at the negedge where start was raised; scrambles inputs after acceptance.
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         if (lat == 0) begin
            start = 1'b0;
            op = 2'($urandom); left = 8'($urandom); right = 8'($urandom); cc_in = 8'($urandom);
         end
         lat++;
      end while (!done && lat < 50);
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [7:0] l,
                        input logic [7:0] r, input logic [7:0] c);
      logic [23:0] e;
      int lat;
      e = ref_model(o, l, r, c);
      @(negedge clk);
      start = 1'b1; op = o; left = l; right = r; cc_in = c;
      wait_done(lat);
      check({tag, "_lat"}, lat, (o[1] && r == 8'h00) ? 1 : 9);
      check({tag, "_res"}, {16'd0, result}, {16'd0, e[23:8]});
      check({tag, "_cc"}, {24'd0, cc_out}, {24'd0, e[7:0]});
      $display("%s op=%0d l=%h r=%h cc_in=%h -> result=%h cc_out=%h lat=%0d",
               tag, o, l, r, c, result, cc_out, lat);
   endtask

   initial begin
      logic [23:0] e;
      int lat;
      rst = 1'b1; hold = 1'b0; start = 1'b0; op = 2'd0; left = 8'd0; right = 8'd0; cc_in = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_cc", {24'd0, cc_out}, 32'hC0);

      // Directed plan vectors with independent constant expectations.
      do_op("mulu_ff_ff", 2'd0, 8'hFF, 8'hFF, 8'h3F);
      check("mulu_ff_ff_const", {16'd0, result}, 32'hFE01);
      check("mulu_ff_ff_ccconst", {24'd0, cc_out}, 32'h3E);
      do_op("mulu_80_01", 2'd0, 8'h80, 8'h01, 8'h00);
      check("mulu_80_01_const", {16'd0, result}, 32'h0080);
      check("mulu_80_01_c", {31'd0, cc_out[0]}, 32'd1);
      do_op("muls_ff_02", 2'd1, 8'hFF, 8'h02, 8'h00);
      check("muls_ff_02_const", {16'd0, result}, 32'hFFFE);
      check("muls_ff_02_ccconst", {24'd0, cc_out}, 32'h09);
      do_op("muls_00_85", 2'd1, 8'h00, 8'h85, 8'h00);
      check("muls_00_85_z", {31'd0, cc_out[2]}, 32'd1);
      do_op("divu_100_7", 2'd2, 8'd100, 8'd7, 8'h00);
      check("divu_100_7_const", {16'd0, result}, 32'h020E);
      do_op("divs_f9_02", 2'd3, 8'hF9, 8'h02, 8'h00);
      check("divs_f9_02_const", {16'd0, result}, 32'hFFFD);
      check("divs_f9_02_n", {31'd0, cc_out[3]}, 32'd1);
      do_op("divu_5a_00", 2'd2, 8'h5A, 8'h00, 8'hC0);
      check("divu_5a_00_const", {16'd0, result}, 32'h5AFF);
      check("divu_5a_00_ccconst", {24'd0, cc_out}, 32'hC3);
      do_op("divs_80_ff", 2'd3, 8'h80, 8'hFF, 8'h00);
      check("divs_80_ff_const", {16'd0, result}, 32'h0080);
      check("divs_80_ff_v", {31'd0, cc_out[1]}, 32'd1);
      do_op("divs_zero", 2'd3, 8'h85, 8'h00, 8'h30);

      // Random operations.
      for (int i = 0; i < 40; i++) begin
         logic [7:0] rr;
         rr = (i % 8 == 7) ? 8'h00 : 8'($urandom);
         do_op("rand", 2'($urandom), 8'($urandom), rr, 8'($urandom));
      end

      // start during RUN is ignored.
      e = ref_model(2'd0, 8'h37, 8'h5B, 8'h00);
      @(negedge clk);
      start = 1'b1; op = 2'd0; left = 8'h37; right = 8'h5B; cc_in = 8'h00;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 2'd2; left = 8'hF0; right = 8'h03; cc_in = 8'hFF;
      lat = 2;
      while (!done && lat < 50) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      check("ign_lat", lat, 9);
      check("ign_res", {16'd0, result}, {16'd0, e[23:8]});
      check("ign_cc", {24'd0, cc_out}, {24'd0, e[7:0]});
      $display("ignore_start result=%h cc_out=%h lat=%0d", result, cc_out, lat);

      // Back-to-back: start raised during the done cycle.
      e = ref_model(2'd3, 8'h9C, 8'h05, 8'h40);
      start = 1'b1; op = 2'd3; left = 8'h9C; right = 8'h05; cc_in = 8'h40;
      wait_done(lat);
      check("b2b_lat", lat, 9);
      check("b2b_res", {16'd0, result}, {16'd0, e[23:8]});
      check("b2b_cc", {24'd0, cc_out}, {24'd0, e[7:0]});
      $display("back_to_back result=%h cc_out=%h lat=%0d", result, cc_out, lat);

      // hold for 3 cycles mid-RUN, then stretch done with hold.
      e = ref_model(2'd0, 8'hA5, 8'h3C, 8'h10);
      @(negedge clk);
      start = 1'b1; op = 2'd0; left = 8'hA5; right = 8'h3C; cc_in = 8'h10;
      lat = 0;
      repeat (4) begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end
      hold = 1'b1;
      repeat (3) begin
         @(negedge clk);
         lat++;
      end
      check("hold_busy", {31'd0, busy}, 32'd1);
      hold = 1'b0;
      while (!done && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("hold_lat", lat, 12);
      check("hold_res", {16'd0, result}, {16'd0, e[23:8]});
      hold = 1'b1;
      @(negedge clk);
      check("hold_done_stretch", {31'd0, done}, 32'd1);
      hold = 1'b0;
      @(negedge clk);
      check("done_drop", {31'd0, done}, 32'd0);
      $display("hold_op result=%h cc_out=%h lat=%0d", result, cc_out, lat);

      // rst at step 4 of a MULU aborts.
      @(negedge clk);
      start = 1'b1; op = 2'd0; left = 8'hC3; right = 8'h7E; cc_in = 8'h00;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_result", {16'd0, result}, 32'd0);
      check("abort_cc", {24'd0, cc_out}, 32'hC0);
      $display("abort busy=%0d done=%0d result=%h cc_out=%h", busy, done, result, cc_out);
      do_op("after_abort", 2'd0, 8'hC3, 8'h7E, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
